uart_reg: RTL and testbench
===========================

Name: uart_reg

Overview:
- UART echo register. Receives 8N1 serial bytes on uart_rx_i, latches each good byte into an 8-bit data register, and retransmits the register contents on uart_tx_o.
- Top-level block of the UART demo. Runs from the single board clock, no PLL required.
- Baud timing is derived from a clock-frequency parameter.

Parameters:
- CLK_FREQ, 10000000, clk_i frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in bit/s.
- Derived constant (not a port): DIV = CLK_FREQ/BAUD_RATE, integer-truncated; 1041 at the defaults.

Ports:
- clk_i  input  1  system clock, 10 MHz by default.
- rst_n_i  input  1  asynchronous active-low reset.
- uart_rx_i  input  1  serial receive line, idle high, asynchronous to clk_i.
- uart_tx_o  output  1  serial transmit line, idle high.

Behaviour:
- Reset: one clock (clk_i); reset is asynchronous and active-low (rst_n_i); all flops clear on rst_n_i low.
  - uart_tx_o=1, data register=0x00, pending=0.
  - RX and TX FSMs go to IDLE.
  - Synchroniser flops reset to 1.
- Reset mid-frame aborts both FSMs immediately. uart_tx_o returns to 1 while reset is asserted. The partial byte is discarded.
- RX input: uart_rx_i passes through a 2-FF synchroniser before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: wait for synced rx=0, then go to START with bit counter cleared.
  - START: after DIV/2 clocks, re-sample. If rx=0, go to DATA. If rx=1, treat as a glitch and return to IDLE.
  - DATA: every DIV clocks, sample 8 bits, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: after DIV clocks, sample. If rx=1, load the shift register into the data register, pulse rx_done for one clock, and return to IDLE. If rx=0 (framing error), discard the byte and wait in STOP until rx=1, then return to IDLE.
- TX FSM states: IDLE, START, DATA, STOP. Each bit lasts exactly DIV clocks.
  - Frame: start bit (0), 8 data bits LSB first from a TX shift register, 1 stop bit (1).
  - IDLE: if pending=1, copy the data register into the TX shift register, clear pending, and go to START. Total latency from rx_done to the uart_tx_o falling edge is at most 3 clocks.
  - STOP: after DIV clocks, return to IDLE. Back-to-back frames carry no extra idle time.
- pending flag: set by rx_done, cleared when TX loads.
- Simultaneous events:
  - rx_done in the same cycle TX loads: pending stays set, so the new byte is sent next.
  - A new byte arriving while TX is busy overwrites the data register. Only the latest byte is sent after the current frame, with no FIFO.
- Arithmetic: baud counters are wide enough to hold DIV-1 (11 bits at the defaults) and wrap to 0 at each bit boundary. The bit counter is 3 bits.
- Line state:
  - uart_tx_o is registered (glitch-free) and never X after reset.
  - A continuous low on rx produces at most one framing error and no echo.

Optional Feature:
- Macro UART_REG_PARITY_EN.
- Defined:
  - Frames are 8E1: an even-parity bit follows data bit 7 on both RX and TX.
  - RX adds a PARITY state; a parity mismatch discards the byte like a framing error.
  - TX sends the even parity of the byte before the stop bit.
- Undefined: plain 8N1 as above, with no parity logic synthesised.

Test Plan:
- Reset: hold rst_n_i low for 120 ns with rx=1 -> uart_tx_o=1 throughout; no TX activity for 1 ms after release.
- Echo sweep: send 0x00..0x1F as 8N1 frames at 9600 baud (104166 ns/bit) with 2 idle bits between frames. For each frame, uart_tx_o must fall within 3 clocks of the RX stop-bit midpoint. Bits sampled at 1.5, 2.5, … bit times after that edge must equal the sent value (e.g. 0x15 -> 1,0,1,0,1,0,0,0), followed by stop=1.
- Pattern: send 0x55, then 0xAA -> echoes 0x55, then 0xAA; each TX bit width is 1041 clocks ±1.
- Framing error: send 0x3C with the stop bit driven 0 for 1 bit time, then idle -> no TX frame. The next good byte 0x12 echoes as 0x12.
- Overrun: send 0x01 then 0x02 back-to-back with no idle, then 0x03 immediately -> echoes 0x01, then 0x03. 0x02 is overwritten if it arrived while TX was busy and pending was already set; otherwise echoes 0x01, 0x02, 0x03 in order, with no corrupted frames.
- Reset mid-frame: assert rst_n_i during TX data bit 4 of 0x7E -> uart_tx_o=1 immediately. After release, a new byte 0x21 echoes as 0x21.

Source files
------------

// File: rtl/uart_reg.sv
// uart_reg: UART echo register.
// Receives serial bytes on uart_rx_i, latches each good byte into an 8-bit
// data register and retransmits the latest byte on uart_tx_o.
// Bit timing is DIV = CLK_FREQ / BAUD_RATE clocks per bit (DIV >= 4).
// Optional build macro UART_REG_PARITY_EN: 8E1 frames (even parity) on
// both RX and TX. Without it, frames are plain 8N1 and no parity logic exists.
module uart_reg #(
  parameter int CLK_FREQ  = 10000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic uart_rx_i,
  output logic uart_tx_o
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_REG_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Receive side
  logic          rx_meta;
  logic          rx_sync;
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_ferr;   // framing error seen, waiting for the line to go idle
  logic          rx_tick;
  logic          rx_par_ok;
  logic          rx_done;

  // Shared register and handshake
  logic [7:0]    data;
  logic          pending;

  // Transmit side
  logic [2:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick;
  logic          tx_load;

  assign rx_tick = (rx_cnt == BIT_LAST);
  assign tx_tick = (tx_cnt == BIT_LAST);

  // A byte is accepted when the stop bit samples high with no framing error
  // outstanding and (when enabled) the parity bit matched.
  assign rx_done = (rx_state == S_STOP) && !rx_ferr && rx_tick && rx_sync && rx_par_ok;

  // TX loads from IDLE, or straight out of the stop bit so that back-to-back
  // frames carry no idle gap.
  assign tx_load = pending && ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_tick));

`ifdef UART_REG_PARITY_EN
  logic rx_par_bad;
  logic tx_par;
  assign rx_par_ok = ~rx_par_bad;
`else
  assign rx_par_ok = 1'b1;
`endif

  // Two-flop synchroniser for the asynchronous receive line (idles high).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM: detect start, sample mid-bit, shift LSB first, check stop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_ferr  <= 1'b0;
`ifdef UART_REG_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_ferr <= 1'b0;
          if (!rx_sync) begin
            rx_state <= S_START;
            // The detection clock already counts toward the half-bit delay,
            // which keeps the sample points close to true bit centres.
            rx_cnt   <= CW'(1);
            rx_bit   <= 3'd0;
          end
        end
        S_START: begin
          if (rx_cnt >= HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) begin
`ifdef UART_REG_PARITY_EN
              rx_state <= S_PARITY;
`else
              rx_state <= S_STOP;
`endif
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_REG_PARITY_EN
        S_PARITY: begin
          if (rx_tick) begin
            rx_cnt     <= '0;
            rx_par_bad <= (^rx_shift) != rx_sync;
            rx_state   <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (rx_ferr) begin
            // Hold here through a broken or stuck-low line; one error only.
            if (rx_sync) begin
              rx_ferr  <= 1'b0;
              rx_state <= S_IDLE;
            end
          end else if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_state <= S_IDLE;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          rx_state <= S_IDLE;
          rx_cnt   <= '0;
        end
      endcase
    end
  end

  // Data register holds the latest good byte; pending survives a same-cycle load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data    <= 8'h00;
      pending <= 1'b0;
    end else begin
      if (rx_done) begin
        data <= rx_shift;
      end
      pending <= rx_done | (pending & ~tx_load);
    end
  end

  // Transmit FSM: registered line output, each bit exactly DIV clocks.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= 3'd0;
      tx_shift  <= 8'h00;
      uart_tx_o <= 1'b1;
`ifdef UART_REG_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else if (tx_load) begin
      tx_state  <= S_START;
      tx_cnt    <= '0;
      tx_bit    <= 3'd0;
      tx_shift  <= data;
      uart_tx_o <= 1'b0;
`ifdef UART_REG_PARITY_EN
      tx_par    <= ^data;
`endif
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_cnt    <= '0;
          uart_tx_o <= 1'b1;
        end
        S_START: begin
          if (tx_tick) begin
            tx_cnt    <= '0;
            tx_state  <= S_DATA;
            uart_tx_o <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) begin
`ifdef UART_REG_PARITY_EN
              tx_state  <= S_PARITY;
              uart_tx_o <= tx_par;
`else
              tx_state  <= S_STOP;
              uart_tx_o <= 1'b1;
`endif
            end else begin
              tx_shift  <= {1'b0, tx_shift[7:1]};
              uart_tx_o <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_REG_PARITY_EN
        S_PARITY: begin
          if (tx_tick) begin
            tx_cnt    <= '0;
            tx_state  <= S_STOP;
            uart_tx_o <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state  <= S_IDLE;
          tx_cnt    <= '0;
          uart_tx_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg.sv
// tb_uart_reg: self-checking bench for uart_reg.
// Runs at 16 clocks per bit so the full plan fits in a short simulation.
// Echoed frames are decoded from uart_tx_o and checked against a scoreboard.
module tb_uart_reg;

  localparam int CLK_FREQ  = 10_000_000;
  localparam int BAUD_RATE = 625_000;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;   // 16
  localparam int CLK_PER   = 100;
  localparam int BIT_T     = DIV * CLK_PER;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rx    = 1'b1;
  logic tx;

  uart_reg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .uart_rx_i(rx),
    .uart_tx_o(tx)
  );

  always #(CLK_PER / 2) clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] val;
    bit         opt;   // echo may legitimately be dropped (overwritten)
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] val;
    logic       stop;
    bit         echo;
  } vec_t;
  vec_t vecs[36];

  longint stop_mid  = 0;
  longint last_fall = 0;
  longint last_edge = -1;
  bit     lat_chk   = 1'b0;
  bit     mon_en    = 1'b0;
  bit     width_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input longint v, input longint lo, input longint hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Drive one frame on rx; stop_val=0 forces a framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_T);
    end
`ifdef UART_REG_PARITY_EN
    rx = ^b;
    #(BIT_T);
`endif
    stop_mid = $time + BIT_T / 2;
    rx = stop_val;
    #(BIT_T);
    rx = 1'b1;
  endtask

  // Decode one TX frame starting at the falling edge just seen.
  task automatic decode_frame();
    logic [7:0] got;
    exp_t       e;
    if (lat_chk) check_range("echo_latency", $time - stop_mid, 0, 3 * CLK_PER);
    #(BIT_T / 2);
    check("start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #(BIT_T);
      got[i] = tx;
    end
`ifdef UART_REG_PARITY_EN
    #(BIT_T);
    check("parity_bit", tx, ^got);
`endif
    #(BIT_T);
    check("stop_bit", tx, 1'b1);
    while (sbq.size() > 1 && sbq[0].opt && sbq[0].val !== got) void'(sbq.pop_front());
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_frame: got %02h required no frame", got);
    end else begin
      e = sbq.pop_front();
      $display("echo frame %02h expected %02h", got, e.val);
      check("echo_byte", got, e.val);
    end
  endtask

  // TX monitor
  initial begin
    forever begin
      @(negedge tx);
      last_fall = $time;
      if (mon_en) decode_frame();
    end
  end

  // Bit-width watcher: adjacent edges one bit apart must be DIV clocks +-1.
  initial begin
    forever begin
      @(tx);
      if (width_chk && last_edge >= 0 && ($time - last_edge) < (BIT_T + BIT_T / 2))
        check_range("bit_width", $time - last_edge, BIT_T - CLK_PER, BIT_T + CLK_PER);
      last_edge = $time;
    end
  end

  function automatic bit only_optional_left();
    foreach (sbq[k]) if (!sbq[k].opt) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 * DIV && !done; i++) begin
      @(posedge clk);
      done = only_optional_left();
    end
    check(name, done, 1'b1);
    sbq.delete();
  endtask

  task automatic watch_idle(input string name, input int cycles);
    bit low_seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check(name, low_seen, 1'b0);
  endtask

  initial begin
    longint dly;

    // Stimulus table: echo sweep, alternating patterns, framing error, recovery.
    for (int i = 0; i < 32; i++) vecs[i] = '{val: 8'(i), stop: 1'b1, echo: 1'b1};
    vecs[32] = '{val: 8'h55, stop: 1'b1, echo: 1'b1};
    vecs[33] = '{val: 8'hAA, stop: 1'b1, echo: 1'b1};
    vecs[34] = '{val: 8'h3C, stop: 1'b0, echo: 1'b0};
    vecs[35] = '{val: 8'h12, stop: 1'b1, echo: 1'b1};

    // Reset: 120 time units low with rx idle; tx must stay high.
    #1 rst_n = 1'b0;
    #29 check("reset_tx_a", tx, 1'b1);
    #40 check("reset_tx_b", tx, 1'b1);
    #40 check("reset_tx_c", tx, 1'b1);
    #11 rst_n = 1'b1;
    watch_idle("idle_after_reset", 20 * DIV);
    mon_en = 1'b1;

    // Table-driven frames with two idle bits between them.
    for (int v = 0; v < 36; v++) begin
      lat_chk   = (v < 32);
      width_chk = (v >= 32 && v <= 33);
      @(negedge clk);
      if (vecs[v].echo) sbq.push_back('{val: vecs[v].val, opt: 1'b0});
      send_frame(vecs[v].val, vecs[v].stop);
      #(2 * BIT_T);
    end
    lat_chk = 1'b0;
    wait_drain("drain_table");
    width_chk = 1'b0;

    // Overrun: three frames back-to-back; the middle one may be overwritten.
    #(4 * BIT_T);
    @(negedge clk);
    sbq.push_back('{val: 8'h01, opt: 1'b0});
    sbq.push_back('{val: 8'h02, opt: 1'b1});
    sbq.push_back('{val: 8'h03, opt: 1'b0});
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    wait_drain("drain_overrun");

    // Reset during TX data bit 4 of the 0x7E echo.
    #(4 * BIT_T);
    mon_en = 1'b0;
    @(negedge clk);
    send_frame(8'h7E, 1'b1);
    check_range("echo_7e_start", last_fall - stop_mid, 0, 3 * CLK_PER);
    dly = last_fall + 5 * BIT_T + BIT_T / 2 - $time;
    if (dly > 0) #(dly);
    check("tx_bit4_of_7e", tx, 1'b1);
    rst_n = 1'b0;
    #1 check("reset_mid_tx", tx, 1'b1);
    #(3 * CLK_PER);
    check("reset_mid_hold", tx, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    watch_idle("no_resume_after_reset", 12 * DIV);
    mon_en = 1'b1;
    @(negedge clk);
    sbq.push_back('{val: 8'h21, opt: 1'b0});
    send_frame(8'h21, 1'b1);
    wait_drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
